apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge_if.sv | 34 +++
 rtl/apb_master_bridge.sv | 151 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus bundle for apb_master_bridge.
// master: the bridge's view. slave: the environment's view (command source,
// response sink and APB completer).
interface apb_master_bridge_if;
  // command side
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // response side
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  // APB
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata, pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwdata, psel, penable, pwrite
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata, pready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwdata, psel, penable, pwrite
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Queued command to APB master bridge: commands are buffered in a FIFO and
// issued one at a time as APB transfers; each transfer returns one response.
// A transfer whose completer never raises pready is ended after TIMEOUT
// ACCESS cycles with rsp_err set.
module apb_master_bridge #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  apb_master_bridge_if.master bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state, state_nxt;

  logic          fifo_write [FIFO_DEPTH];
  logic [31:0]   fifo_addr  [FIFO_DEPTH];
  logic [31:0]   fifo_wdata [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  logic [TW-1:0] tcnt;
  logic          done, timed_out;

  assign full          = (count == CW'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign bus.req_ready = !full;
  assign push          = bus.req_valid && !full;

  // FIFO storage; no reset needed, occupancy tracks validity
  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_write[wr_ptr] <= bus.req_write;
      fifo_addr[wr_ptr]  <= bus.req_addr;
      fifo_wdata[wr_ptr] <= bus.req_wdata;
    end
  end

  // FIFO pointers and registered occupancy
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state, FIFO pop and transfer-end decisions
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = SETUP;
          pop       = 1'b1;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          state_nxt = RESP;
          done      = 1'b1;
        end else if (tcnt == TLIM) begin
          state_nxt = RESP;
          done      = 1'b1;
          timed_out = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          if (!empty) begin
            state_nxt = SETUP;
            pop       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ACCESS cycle counter, zero on every entry into ACCESS
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)             tcnt <= '0;
    else if (state == ACCESS) tcnt <= tcnt + TW'(1);
    else                      tcnt <= '0;
  end

  // registered APB and response outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      // handshake and pop can coincide: response retires as next SETUP begins
      if (state == RESP && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
        bus.rsp_err   <= 1'b0;
        bus.rsp_rdata <= '0;
      end
      if (pop) begin
        bus.paddr   <= fifo_addr[rd_ptr];
        bus.pwdata  <= fifo_wdata[rd_ptr];
        bus.pwrite  <= fifo_write[rd_ptr];
        bus.psel    <= 1'b1;
        bus.penable <= 1'b0;
      end
      if (state == SETUP) bus.penable <= 1'b1;
      if (done) begin
        bus.psel      <= 1'b0;
        bus.penable   <= 1'b0;
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= timed_out;
        bus.rsp_rdata <= (timed_out || bus.pwrite) ? '0 : bus.prdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small APB completer model
// (optional 16-bit data width, programmable pready wait).
module tb_apb_master_bridge;

  logic pclk;
  logic presetn;

  apb_master_bridge_if bus ();

  apb_master_bridge #(
    .FIFO_DEPTH(4),
    .TIMEOUT   (16)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } apb_t;

  typedef struct packed {
    logic        e;
    logic [31:0] d;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;

  // completer model
  logic [31:0] mem [16];
  logic        narrow;
  int          wait_cycles;
  int          acc_cnt = 0;

  assign bus.pready = (acc_cnt >= wait_cycles);
  assign bus.prdata = narrow ? {16'h0, mem[bus.paddr[5:2]][15:0]} : mem[bus.paddr[5:2]];

  always @(posedge pclk) begin
    if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
    else                                         acc_cnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite)
      mem[bus.paddr[5:2]] <= narrow ? {16'h0, bus.pwdata[15:0]} : bus.pwdata;
  end

  // monitors
  apb_t        apbq[$];
  rsp_t        rspq[$];
  int          pen_cnt   = 0;
  int          setup_cnt = 0;
  logic        unstable  = 1'b0;
  logic        viol      = 1'b0;
  logic [31:0] hold_a, hold_d;
  logic        hold_w;

  always @(posedge pclk) begin
    if (bus.psel && bus.penable && bus.pready) apbq.push_back({bus.pwrite, bus.paddr, bus.pwdata});
    if (bus.rsp_valid && bus.rsp_ready)      rspq.push_back({bus.rsp_err, bus.rsp_rdata});
    if (bus.penable) pen_cnt++;
    if (bus.psel && !bus.penable) begin
      setup_cnt++;
      hold_a = bus.paddr;
      hold_d = bus.pwdata;
      hold_w = bus.pwrite;
    end
    if (bus.psel && bus.penable &&
        (bus.paddr != hold_a || bus.pwdata != hold_d || bus.pwrite != hold_w))
      unstable = 1'b1;
  end

  always @(negedge pclk) if (bus.penable && !bus.psel) viol = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge pclk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 300) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 300) chk("push_wait", 32'(bus.req_ready), 32'd1);
    @(posedge pclk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int t = 0;
    while (rspq.size() < n && t < 300) begin
      @(negedge pclk);
      t++;
    end
    if (rspq.size() < n) chk("rsp_wait", 32'(rspq.size()), 32'(n));
  endtask

  task automatic get_rsp(input string tag, input logic e, input logic [31:0] d);
    rsp_t r = '0;
    if (rspq.size() > 0) r = rspq.pop_front();
    else chk({tag, "_present"}, 32'd0, 32'd1);
    chk({tag, "_err"}, 32'(r.e), 32'(e));
    chk({tag, "_rdata"}, r.d, d);
  endtask

  task automatic get_apb(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
    apb_t x = '0;
    if (apbq.size() > 0) x = apbq.pop_front();
    else chk({tag, "_present"}, 32'd0, 32'd1);
    chk({tag, "_pwrite"}, 32'(x.w), 32'(w));
    chk({tag, "_paddr"}, x.a, a);
    if (w) chk({tag, "_pwdata"}, x.d, d);
  endtask

  logic [31:0] exp_a [5] = '{32'h10, 32'h14, 32'h10, 32'h14, 32'h18};
  logic        exp_w [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] exp_d [5] = '{32'h0, 32'h0, 32'h11111111, 32'h22222222, 32'h0};
  logic [31:0] wd    [5] = '{32'h11111111, 32'h22222222, 32'h0, 32'h0, 32'h33333333};

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int p0;
    presetn       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    wait_cycles   = 0;
    narrow        = 1'b0;

    // reset state
    repeat (3) @(negedge pclk);
    chk("rst_psel", 32'(bus.psel), 0);
    chk("rst_penable", 32'(bus.penable), 0);
    chk("rst_pwrite", 32'(bus.pwrite), 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rst_req_ready", 32'(bus.req_ready), 1);

    // cycle-exact write, then read back
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'hDEADBEEF;
    @(posedge pclk);
    #1 bus.req_valid = 1'b0;
    chk("k0_psel", 32'(bus.psel), 0);
    @(posedge pclk); #1;
    chk("k1_psel", 32'(bus.psel), 1);
    chk("k1_penable", 32'(bus.penable), 0);
    chk("k1_paddr", bus.paddr, 32'h0);
    chk("k1_pwdata", bus.pwdata, 32'hDEADBEEF);
    chk("k1_pwrite", 32'(bus.pwrite), 1);
    @(posedge pclk); #1;
    chk("k2_psel", 32'(bus.psel), 1);
    chk("k2_penable", 32'(bus.penable), 1);
    @(posedge pclk); #1;
    chk("k3_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("k3_psel", 32'(bus.psel), 0);
    chk("k3_penable", 32'(bus.penable), 0);
    chk("k3_rsp_err", 32'(bus.rsp_err), 0);
    chk("k3_rsp_rdata", bus.rsp_rdata, 0);
    @(posedge pclk); #1;
    chk("k4_rsp_valid", 32'(bus.rsp_valid), 0);
    wait_rsp(1);
    get_rsp("wr0", 1'b0, 32'h0);
    push(1'b0, 32'h0, 32'h0);
    wait_rsp(1);
    get_rsp("rd0", 1'b0, 32'hDEADBEEF);
    get_apb("apb_wr0", 1'b1, 32'h0, 32'hDEADBEEF);
    get_apb("apb_rd0", 1'b0, 32'h0, 32'h0);

    // 16-bit completer
    narrow = 1'b1;
    push(1'b1, 32'h4, 32'h1234ABCD);
    push(1'b0, 32'h4, 32'h0);
    wait_rsp(2);
    get_rsp("n_wr4", 1'b0, 32'h0);
    get_rsp("n_rd4", 1'b0, 32'h0000ABCD);
    apbq.delete();
    narrow = 1'b0;

    // back-pressure: five commands with responses stalled
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(exp_w[i], exp_a[i], wd[i]);
    @(negedge pclk);
    chk("bp_req_ready", 32'(bus.req_ready), 0);
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("bp_one_issued", 32'(apbq.size()), 1);
    bus.rsp_ready = 1'b1;
    wait_rsp(5);
    for (int i = 0; i < 5; i++) begin
      get_rsp($sformatf("bp_rsp%0d", i), 1'b0, exp_d[i]);
      get_apb($sformatf("bp_apb%0d", i), exp_w[i], exp_a[i], wd[i]);
    end

    // timeout on read 0x8
    push(1'b1, 32'h8, 32'h55AA55AA);
    wait_rsp(1);
    get_rsp("to_prep", 1'b0, 32'h0);
    apbq.delete();
    wait_cycles = 1000;
    p0 = pen_cnt;
    push(1'b0, 32'h8, 32'h0);
    wait_rsp(1);
    get_rsp("to_rd8", 1'b1, 32'h0);
    chk("to_penable_cycles", 32'(pen_cnt - p0), 32'd16);
    wait_cycles = 0;
    push(1'b0, 32'h0, 32'h0);
    wait_rsp(1);
    get_rsp("to_next", 1'b0, 32'hDEADBEEF);
    apbq.delete();

    // three wait states
    wait_cycles = 3;
    p0 = pen_cnt;
    push(1'b1, 32'h1C, 32'hCAFEF00D);
    wait_rsp(1);
    get_rsp("ws_wr", 1'b0, 32'h0);
    chk("ws_penable_cycles", 32'(pen_cnt - p0), 32'd4);
    chk("ws_stable", 32'(unstable), 0);
    wait_cycles = 0;
    push(1'b0, 32'h1C, 32'h0);
    wait_rsp(1);
    get_rsp("ws_rd", 1'b0, 32'hCAFEF00D);
    apbq.delete();

    // reset during ACCESS with two queued
    wait_cycles = 1000;
    push(1'b0, 32'h0, 32'h0);
    push(1'b1, 32'h20, 32'hAAAA0001);
    push(1'b1, 32'h24, 32'hAAAA0002);
    for (int t = 0; t < 50 && !bus.penable; t++) @(negedge pclk);
    chk("ra_in_access", 32'(bus.penable), 1);
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    chk("ra_psel", 32'(bus.psel), 0);
    chk("ra_penable", 32'(bus.penable), 0);
    chk("ra_paddr", bus.paddr, 0);
    chk("ra_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("ra_req_ready", 32'(bus.req_ready), 1);
    repeat (2) @(negedge pclk);
    presetn     = 1'b1;
    wait_cycles = 0;
    p0          = setup_cnt;
    repeat (20) @(negedge pclk);
    chk("ra_no_rsp", 32'(rspq.size()), 0);
    chk("ra_no_setup", 32'(setup_cnt - p0), 0);
    chk("ra_no_apb", 32'(apbq.size()), 0);
    chk("ra_fifo_empty", 32'(bus.psel), 0);

    chk("protocol_penable_wo_psel", 32'(viol), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
